// File: rtl/lane_scroll_ctrl.sv
// Lane-dash scroll scheduler: advances dash y positions once per frame in vertical blank
// and arbitrates per-dash pixels into one registered stream. Optional macro: LANE_SCROLL_ACCEL_EN.
module lane_scroll_ctrl #(
   parameter int NUM_DASH   = 4,
   parameter int DASH_PITCH = 160,
   parameter int SCREEN_H   = 480,
   parameter int LANE_X     = 305
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  enable,
   input  logic                  pause,
   input  logic [9:0]            vcount,
   input  logic [3:0]            speed_in,
   input  logic                  speed_load,
   input  logic [NUM_DASH-1:0]   dash_data,
   input  logic [NUM_DASH*8-1:0] dash_rgb,
   output logic [9:0]            dash_posx,
   output logic [NUM_DASH*10-1:0] dash_posy,
   output logic [NUM_DASH-1:0]   dash_enable,
   output logic                  frame_tick,
   output logic [2:0]            red,
   output logic [2:0]            green,
   output logic [1:0]            blue,
   output logic                  data
);

   localparam int IDX_W = (NUM_DASH > 1) ? $clog2(NUM_DASH) : 1;
   localparam logic [10:0] WRAP11  = 11'(NUM_DASH * DASH_PITCH);
   localparam logic [10:0] PITCH11 = 11'(DASH_PITCH);
   localparam logic [10:0] H11     = 11'(SCREEN_H);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DASH - 1);

   typedef enum logic [1:0] {IDLE, WAIT, UPDATE, CALC} state_t;

   state_t           state, state_next;
   logic [9:0]       base;
   logic [3:0]       speed, speed_tgt, speed_eff;
   logic [IDX_W-1:0] idx;
   logic [9:0]       vcount_prev;
   logic             tick_now;
   logic [10:0]      base_sum, base_wrapped;
   logic [10:0]      calc_sum, calc_pos;
   logic [9:0]       posy_reg [NUM_DASH];
   logic             en_reg   [NUM_DASH];
   logic             win_data;
   logic [7:0]       win_rgb;

   assign dash_posx = 10'(LANE_X);
   assign tick_now  = (vcount == H11[9:0]) && (vcount_prev != H11[9:0]);

   always_comb begin
`ifdef LANE_SCROLL_ACCEL_EN
      if (speed < speed_tgt)      speed_eff = speed + 4'd1;
      else if (speed > speed_tgt) speed_eff = speed - 4'd1;
      else                        speed_eff = speed;
`else
      speed_eff = (speed == speed_tgt) ? speed : speed_tgt;
`endif
   end

   always_comb begin
      base_sum     = {1'b0, base} + {7'b0, speed_eff};
      base_wrapped = (base_sum >= WRAP11) ? base_sum - WRAP11 : base_sum;
      calc_sum     = {1'b0, base} + 11'(idx) * PITCH11;
      calc_pos     = (calc_sum >= WRAP11) ? calc_sum - WRAP11 : calc_sum;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (enable) state_next = WAIT;
         WAIT:    if (tick_now && !pause) state_next = UPDATE;
         UPDATE:  state_next = CALC;
         CALC:    if (idx == LAST_IDX) state_next = WAIT;
         default: state_next = IDLE;
      endcase
      if (!enable) state_next = IDLE;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         base        <= '0;
         speed       <= '0;
         speed_tgt   <= '0;
         idx         <= '0;
         vcount_prev <= '0;
         frame_tick  <= 1'b0;
      end else begin
         state       <= state_next;
         vcount_prev <= vcount;
         frame_tick  <= tick_now;
         if (speed_load) speed_tgt <= speed_in;
         if (state == IDLE) base <= '0;
         if (state == UPDATE) begin
            base  <= base_wrapped[9:0];
            speed <= speed_eff;
            idx   <= '0;
         end
         if (state == CALC) idx <= idx + 1'b1;
      end
   end

   // One instance is refreshed per CALC cycle; reset positions are evenly spaced.
   for (genvar gi = 0; gi < NUM_DASH; gi++) begin : g_dash
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            posy_reg[gi] <= 10'(gi * DASH_PITCH);
            en_reg[gi]   <= 1'b0;
         end else if (!enable || state == IDLE) begin
            en_reg[gi]   <= 1'b0;
         end else if (state == CALC && idx == IDX_W'(gi)) begin
            posy_reg[gi] <= calc_pos[9:0];
            en_reg[gi]   <= (calc_pos < H11);
         end
      end
      assign dash_posy[10*gi +: 10] = posy_reg[gi];
      assign dash_enable[gi]        = en_reg[gi];
   end

   always_comb begin
      win_data = 1'b0;
      win_rgb  = 8'd0;
      for (int i = NUM_DASH - 1; i >= 0; i--) begin
         if (dash_data[i]) begin
            win_data = 1'b1;
            win_rgb  = dash_rgb[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         red   <= '0;
         green <= '0;
         blue  <= '0;
         data  <= 1'b0;
      end else begin
         {red, green, blue} <= win_rgb;
         data               <= win_data;
      end
   end

endmodule

// File: tb/tb_lane_scroll_ctrl.sv
// Scoreboard bench for lane_scroll_ctrl: stimulus queues expected snapshots/pixels,
// independent monitors pop and compare when the DUT presents them.
module tb_lane_scroll_ctrl;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        enable, pause, speed_load;
   logic [9:0]  vcount;
   logic [3:0]  speed_in;
   logic [3:0]  dash_data;
   logic [31:0] dash_rgb;
   logic [9:0]  dash_posx;
   logic [39:0] dash_posy;
   logic [3:0]  dash_enable;
   logic        frame_tick;
   logic [2:0]  red, green;
   logic [1:0]  blue;
   logic        data;

   always #5 clock = ~clock;

   lane_scroll_ctrl dut (
      .clock(clock), .reset_n(reset_n), .enable(enable), .pause(pause),
      .vcount(vcount), .speed_in(speed_in), .speed_load(speed_load),
      .dash_data(dash_data), .dash_rgb(dash_rgb), .dash_posx(dash_posx),
      .dash_posy(dash_posy), .dash_enable(dash_enable), .frame_tick(frame_tick),
      .red(red), .green(green), .blue(blue), .data(data)
   );

   typedef struct {
      logic [39:0] posy;
      logic [3:0]  en;
      logic        chk_out;
   } snap_t;

   typedef struct {
      logic [2:0] r;
      logic [2:0] g;
      logic [1:0] b;
      logic       d;
   } pix_t;

   snap_t pos_q[$];
   pix_t  pix_q[$];
   int compared   = 0;
   int mismatched = 0;
   int tick_cnt   = 0;
   logic snap_req = 1'b0;
   logic pix_req  = 1'b0;

   function automatic snap_t mk(int p3, int p2, int p1, int p0, logic [3:0] en, logic co);
      snap_t s;
      s.posy    = {10'(p3), 10'(p2), 10'(p1), 10'(p0)};
      s.en      = en;
      s.chk_out = co;
      return s;
   endfunction

   function automatic snap_t from_base(int b);
      snap_t s;
      s.chk_out = 1'b0;
      for (int i = 0; i < 4; i++) begin
         int p;
         p = (b + 160 * i) % 640;
         s.posy[10*i +: 10] = 10'(p);
         s.en[i] = (p < 480);
      end
      return s;
   endfunction

   task automatic check_pos(input string tag);
      snap_t e;
      compared++;
      if (pos_q.size() == 0) begin
         mismatched++;
         $display("FAIL %s: unexpected position update posy=%0d,%0d,%0d,%0d required none", tag,
                  dash_posy[39:30], dash_posy[29:20], dash_posy[19:10], dash_posy[9:0]);
         return;
      end
      e = pos_q.pop_front();
      if (dash_posy !== e.posy || dash_enable !== e.en) begin
         mismatched++;
         $display("FAIL %s: posy=%0d,%0d,%0d,%0d en=%b required posy=%0d,%0d,%0d,%0d en=%b", tag,
                  dash_posy[39:30], dash_posy[29:20], dash_posy[19:10], dash_posy[9:0], dash_enable,
                  e.posy[39:30], e.posy[29:20], e.posy[19:10], e.posy[9:0], e.en);
      end else begin
         $display("ok %s: posy=%0d,%0d,%0d,%0d en=%b", tag,
                  dash_posy[39:30], dash_posy[29:20], dash_posy[19:10], dash_posy[9:0], dash_enable);
      end
      if (e.chk_out) begin
         compared++;
         if ({frame_tick, red, green, blue, data} !== 10'd0 || dash_posx !== 10'd305) begin
            mismatched++;
            $display("FAIL %s_outs: tick=%b rgb=%b%b%b data=%b posx=%0d required zeros posx=305",
                     tag, frame_tick, red, green, blue, data, dash_posx);
         end else begin
            $display("ok %s_outs: outputs at reset values", tag);
         end
      end
   endtask

   task automatic check_pix();
      pix_t e;
      compared++;
      if (pix_q.size() == 0) begin
         mismatched++;
         $display("FAIL pixel: no expected entry queued");
         return;
      end
      e = pix_q.pop_front();
      if (red !== e.r || green !== e.g || blue !== e.b || data !== e.d) begin
         mismatched++;
         $display("FAIL pixel: rgb=%b_%b_%b data=%b required rgb=%b_%b_%b data=%b",
                  red, green, blue, data, e.r, e.g, e.b, e.d);
      end else begin
         $display("ok pixel: rgb=%b_%b_%b data=%b", red, green, blue, data);
      end
   endtask

   // Position monitor: a frame pass completes NUM_DASH+2 cycles after frame_tick.
   initial begin
      int cd;
      cd = 0;
      forever begin
         @(negedge clock);
         if (!reset_n) cd = 0;
         if (snap_req) check_pos("snapshot");
         if (cd > 0) begin
            cd--;
            if (cd == 0) check_pos("frame");
         end
         if (frame_tick) begin
            tick_cnt++;
            cd = 6;
         end
      end
   end

   initial begin
      logic due;
      forever begin
         @(posedge clock);
         due = pix_req;
         @(negedge clock);
         if (due) check_pix();
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_tick();
      @(posedge clock); #1 vcount = 10'd479;
      @(posedge clock); #1 vcount = 10'd480;
      repeat (3) @(posedge clock);
      #1 vcount = 10'd481;
      repeat (8) @(posedge clock);
   endtask

   task automatic load_speed(input logic [3:0] s);
      @(posedge clock); #1 speed_in = s; speed_load = 1'b1;
      @(posedge clock); #1 speed_load = 1'b0; speed_in = 4'd0;
   endtask

   task automatic snapshot(input snap_t e);
      pos_q.push_back(e);
      snap_req = 1'b1;
      @(negedge clock);
      #1 snap_req = 1'b0;
   endtask

   task automatic drive_pix(input logic [3:0] d, input logic [31:0] rgb, input pix_t e);
      @(posedge clock); #1;
      dash_data = d;
      dash_rgb  = rgb;
      pix_q.push_back(e);
      pix_req = 1'b1;
      @(posedge clock); #1;
      pix_req   = 1'b0;
      dash_data = 4'd0;
      dash_rgb  = 32'd0;
   endtask

   initial begin
      int cnt0;
      pix_t pe;
      reset_n = 1'b0; enable = 1'b1; pause = 1'b0; speed_load = 1'b0;
      vcount = 10'd0; speed_in = 4'd0; dash_data = 4'd0; dash_rgb = 32'd0;
      #12;
      snapshot(mk(480, 320, 160, 0, 4'b0000, 1'b1));
      @(posedge clock); #1 reset_n = 1'b1;
      repeat (3) @(posedge clock);

`ifndef LANE_SCROLL_ACCEL_EN
      load_speed(4'd4);
      pos_q.push_back(mk(484, 324, 164, 4, 4'b0111, 1'b0));
      do_tick();
      load_speed(4'd8);
      for (int k = 1; k <= 79; k++) begin
         pos_q.push_back(from_base(4 + 8 * k));
         do_tick();
      end
      // base 636 + 8 wraps to 4
      pos_q.push_back(mk(484, 324, 164, 4, 4'b0111, 1'b0));
      do_tick();
`else
      load_speed(4'd3);
      pos_q.push_back(mk(481, 321, 161, 1, 4'b0111, 1'b0));
      do_tick();
      pos_q.push_back(mk(483, 323, 163, 3, 4'b0111, 1'b0));
      do_tick();
      pos_q.push_back(mk(486, 326, 166, 6, 4'b0111, 1'b0));
      do_tick();
      pos_q.push_back(mk(489, 329, 169, 9, 4'b0111, 1'b0));
      do_tick();
`endif

      @(posedge clock); #1 pause = 1'b1;
      cnt0 = tick_cnt;
      for (int k = 0; k < 3; k++) begin
`ifndef LANE_SCROLL_ACCEL_EN
         pos_q.push_back(mk(484, 324, 164, 4, 4'b0111, 1'b0));
`else
         pos_q.push_back(mk(489, 329, 169, 9, 4'b0111, 1'b0));
`endif
         do_tick();
      end
      compared++;
      if (tick_cnt - cnt0 != 3) begin
         mismatched++;
         $display("FAIL pause_ticks: frame_tick cycles=%0d required 3", tick_cnt - cnt0);
      end else begin
         $display("ok pause_ticks: frame_tick cycles=3");
      end
      @(posedge clock); #1 pause = 1'b0;

      @(posedge clock); #1 enable = 1'b0;
      repeat (2) @(posedge clock);
`ifndef LANE_SCROLL_ACCEL_EN
      snapshot(mk(484, 324, 164, 4, 4'b0000, 1'b0));
      @(posedge clock); #1 enable = 1'b1;
      pos_q.push_back(mk(488, 328, 168, 8, 4'b0111, 1'b0));
`else
      snapshot(mk(489, 329, 169, 9, 4'b0000, 1'b0));
      @(posedge clock); #1 enable = 1'b1;
      pos_q.push_back(mk(483, 323, 163, 3, 4'b0111, 1'b0));
`endif
      do_tick();

      pe = '{r: 3'b111, g: 3'b000, b: 2'b00, d: 1'b1};
      drive_pix(4'b0110, {8'h00, 8'h1C, 8'hE0, 8'h00}, pe);
      pe = '{r: 3'b000, g: 3'b000, b: 2'b00, d: 1'b0};
      drive_pix(4'b0000, {8'hFF, 8'hFF, 8'hFF, 8'hFF}, pe);
      pe = '{r: 3'b010, g: 3'b110, b: 2'b10, d: 1'b1};
      drive_pix(4'b1000, {8'h5A, 8'h11, 8'h22, 8'h33}, pe);
      pe = '{r: 3'b001, g: 3'b010, b: 2'b11, d: 1'b1};
      drive_pix(4'b1111, {8'hFF, 8'hFF, 8'hFF, 8'h2B}, pe);

      // reset asserted in the middle of a CALC pass
      @(posedge clock); #1 vcount = 10'd479;
      @(posedge clock); #1 vcount = 10'd480;
      repeat (3) @(posedge clock);
      #1 reset_n = 1'b0; vcount = 10'd0;
      snapshot(mk(480, 320, 160, 0, 4'b0000, 1'b1));
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
      repeat (10) @(posedge clock);

      compared++;
      if (pos_q.size() != 0 || pix_q.size() != 0) begin
         mismatched++;
         $display("FAIL drain: pending pos=%0d pix=%0d required 0 0", pos_q.size(), pix_q.size());
      end else begin
         $display("ok drain: all expectations consumed");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
